// File: rtl/rtc_pixel_generator_if.sv
// rtl/rtc_pixel_generator_if.sv - scan/colour link between the VGA controller and the time pixel source
//
// Purpose : bundles the scan coordinates, the frame marker and the returned
//           pixel colour exchanged between the VGA timing controller and
//           rtc_pixel_generator.
// Signals : video_on    - high while pixel_x/pixel_y lie in the visible area
//           pixel_x     - current column, 0-639
//           pixel_y     - current row, 0-479
//           frame_start - one-clk pulse, asserted only in vertical blanking
//           rgb         - 3-bit pixel colour, 2 clks behind the coordinates
// Modports: master - VGA controller side (drives the scan, receives rgb)
//           slave  - pixel generator side (receives the scan, drives rgb)

interface rtc_pixel_generator_if;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_start;
   logic [2:0] rgb;

   modport master (
      output video_on,
      output pixel_x,
      output pixel_y,
      output frame_start,
      input  rgb
   );

   modport slave (
      input  video_on,
      input  pixel_x,
      input  pixel_y,
      input  frame_start,
      output rgb
   );
endinterface

// File: rtl/rtc_pixel_generator.sv
// rtl/rtc_pixel_generator.sv - renders RTC time as scaled "HH:MM:SS" text into the VGA pixel stream
//
// Purpose : draws the time in an 8x16 bitmap font at scale 2 inside a
//           128x32 px box whose top-left corner is (X0, Y0). Each pixel is
//           returned through a fixed 2-clk pipeline. Time digits are shadowed
//           once per frame so a frame never shows a half-updated time, and
//           the two colons blink with a half-period of BLINK_FRAMES frames.
// Ports   : clk        - system clock (50 MHz)
//           rst        - synchronous, active-high reset
//           io_vga     - slave side of the scan link: video_on, pixel_x,
//                        pixel_y, frame_start in; rgb out
//           i_hora     - hours, packed BCD
//           i_min      - minutes, packed BCD
//           i_seg      - seconds, packed BCD

module rtc_pixel_generator #(
   parameter int unsigned X0           = 256,
   parameter int unsigned Y0           = 224,
   parameter logic [2:0]  COLOR_FG     = 3'b010,
   parameter logic [2:0]  COLOR_BG     = 3'b000,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   rst,
   rtc_pixel_generator_if.slave   io_vga,
   input  logic [7:0]             i_hora,
   input  logic [7:0]             i_min,
   input  logic [7:0]             i_seg
);

   localparam logic [10:0] LP_X0         = 11'(X0);
   localparam logic [10:0] LP_Y0         = 11'(Y0);
   localparam logic [5:0]  LP_BLINK_LAST = 6'(BLINK_FRAMES - 1);
   localparam logic [3:0]  GLYPH_COLON   = 4'd10;
   localparam logic [3:0]  GLYPH_BLANK   = 4'd11;

   // Font: one 128-bit word per glyph, row 0 in the most significant byte,
   // bit 7 of each byte is the leftmost pixel.
   function automatic logic [127:0] f_glyph(input logic [3:0] code);
      logic [127:0] v;
      v = 128'h0;
      case (code)
         4'd0:    v = 128'h0000_3C66_666E_7E76_6666_6666_3C00_0000;
         4'd1:    v = 128'h0000_1838_7818_1818_1818_1818_7E00_0000;
         4'd2:    v = 128'h0000_3C66_0606_0C18_3060_6066_7E00_0000;
         4'd3:    v = 128'h0000_3C66_0606_1C06_0606_0666_3C00_0000;
         4'd4:    v = 128'h0000_0C1C_3C6C_CCCC_FE0C_0C0C_1E00_0000;
         4'd5:    v = 128'h0000_7E60_6060_7C06_0606_0666_3C00_0000;
         4'd6:    v = 128'h0000_1C30_6060_7C66_6666_6666_3C00_0000;
         4'd7:    v = 128'h0000_7E66_0606_0C18_1818_1818_1800_0000;
         4'd8:    v = 128'h0000_3C66_6666_3C66_6666_6666_3C00_0000;
         4'd9:    v = 128'h0000_3C66_6666_663E_0606_060C_3800_0000;
         4'd10:   v = 128'h0000_0000_1818_0000_0000_1818_0000_0000;
         default: v = 128'h0;
      endcase
      return v;
   endfunction

   // Out-of-range BCD nibbles render as blank rather than garbage.
   function automatic logic [3:0] f_digit(input logic [3:0] nib);
      return (nib > 4'd9) ? GLYPH_BLANK : nib;
   endfunction

   // Frame-shadowed time and blink state
   logic [7:0] r_sh_hora;
   logic [7:0] r_sh_min;
   logic [7:0] r_sh_seg;
   logic [5:0] r_blink_cnt;
   logic       r_colon_on;

   // Stage 1 pipeline
   logic       r_in_box_d1;
   logic       r_video_on_d1;
   logic [3:0] r_code_d1;
   logic [3:0] r_row_d1;
   logic [2:0] r_bit_d1;

   // Stage 2 output
   logic [2:0] r_rgb;

   logic [10:0]  w_dx;
   logic [10:0]  w_dy;
   logic         w_in_box;
   logic [3:0]   w_code;
   logic [127:0] w_glyph;
   logic [7:0]   w_font_row;
   logic         w_font_bit;
   logic         w_unused_lsb;

   // Modulo-2048 subtraction: left of / above the box wraps to a large value,
   // so a single unsigned compare per axis gives the box test.
   assign w_dx     = {1'b0, io_vga.pixel_x} - LP_X0;
   assign w_dy     = {1'b0, io_vga.pixel_y} - LP_Y0;
   assign w_in_box = (w_dx < 11'd128) && (w_dy < 11'd32);

   // Scale 2 drops the lsb of each offset.
   assign w_unused_lsb = ^{w_dx[0], w_dy[0]};

   always_comb begin
      w_code = GLYPH_BLANK;
      case (w_dx[6:4])
         3'd0:    w_code = f_digit(r_sh_hora[7:4]);
         3'd1:    w_code = f_digit(r_sh_hora[3:0]);
         3'd2:    w_code = r_colon_on ? GLYPH_COLON : GLYPH_BLANK;
         3'd3:    w_code = f_digit(r_sh_min[7:4]);
         3'd4:    w_code = f_digit(r_sh_min[3:0]);
         3'd5:    w_code = r_colon_on ? GLYPH_COLON : GLYPH_BLANK;
         3'd6:    w_code = f_digit(r_sh_seg[7:4]);
         3'd7:    w_code = f_digit(r_sh_seg[3:0]);
         default: w_code = GLYPH_BLANK;
      endcase
   end

   // Font lookup on the stage-1 registers; ~row / ~bit are 15-row / 7-bit.
   assign w_glyph    = f_glyph(r_code_d1);
   assign w_font_row = w_glyph[{~r_row_d1, 3'b000} +: 8];
   assign w_font_bit = w_font_row[~r_bit_d1];

   // Shadow load and colon blink. Both act on the same frame_start edge, so
   // a wrapping pulse loads new time and toggles the colons together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_hora   <= 8'h00;
         r_sh_min    <= 8'h00;
         r_sh_seg    <= 8'h00;
         r_blink_cnt <= 6'd0;
         r_colon_on  <= 1'b1;
      end else if (io_vga.frame_start) begin
         r_sh_hora <= i_hora;
         r_sh_min  <= i_min;
         r_sh_seg  <= i_seg;
         if (r_blink_cnt == LP_BLINK_LAST) begin
            r_blink_cnt <= 6'd0;
            r_colon_on  <= ~r_colon_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 6'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_box_d1   <= 1'b0;
         r_video_on_d1 <= 1'b0;
         r_code_d1     <= 4'd0;
         r_row_d1      <= 4'd0;
         r_bit_d1      <= 3'd0;
      end else begin
         r_in_box_d1   <= w_in_box;
         r_video_on_d1 <= io_vga.video_on;
         r_code_d1     <= w_code;
         r_row_d1      <= w_dy[4:1];
         r_bit_d1      <= w_dx[3:1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rgb <= 3'b000;
      end else if (!r_video_on_d1) begin
         r_rgb <= 3'b000;
      end else if (r_in_box_d1 && w_font_bit) begin
         r_rgb <= COLOR_FG;
      end else begin
         r_rgb <= COLOR_BG;
      end
   end

   assign io_vga.rgb = r_rgb;

endmodule

// File: tb/tb_rtc_pixel_generator.sv
// tb/tb_rtc_pixel_generator.sv - directed self-checking bench for rtc_pixel_generator

module tb_rtc_pixel_generator;

   localparam int         X0  = 256;
   localparam int         Y0  = 224;
   localparam logic [2:0] FG  = 3'b010;
   localparam logic [2:0] BG  = 3'b000;
   localparam logic [2:0] OFF = 3'b000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] hora = 8'h00;
   logic [7:0] min  = 8'h00;
   logic [7:0] seg  = 8'h00;

   int n_pass  = 0;
   int n_total = 0;

   rtc_pixel_generator_if vga ();

   rtc_pixel_generator dut (
      .clk    (clk),
      .rst    (rst),
      .io_vga (vga),
      .i_hora (hora),
      .i_min  (min),
      .i_seg  (seg)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input int x, input int y, input logic v);
      vga.pixel_x  = 10'(x);
      vga.pixel_y  = 10'(y);
      vga.video_on = v;
   endtask

   // Hold one coordinate and read the colour 2 clks later.
   task automatic pix(input int x, input int y, input logic v, output logic [2:0] c);
      @(negedge clk);
      drive(x, y, v);
      @(posedge clk);
      @(posedge clk);
      #1;
      c = vga.rgb;
   endtask

   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vga.frame_start = 1'b1;
         @(negedge clk);
         vga.frame_start = 1'b0;
      end
   endtask

   // Streams one pixel per clk over a rectangle. The colour seen at a negedge
   // belongs to the coordinate driven two negedges earlier.
   // bad: FG outside the box or in padding rows 0,1,14,15, or an illegal colour.
   task automatic sweep(input int x0, input int x1, input int y0, input int y1,
                        output int fg_cnt, output int fg_bad, output int fg01, output int sig);
      int nx;
      int n;
      nx     = x1 - x0 + 1;
      n      = nx * (y1 - y0 + 1);
      fg_cnt = 0;
      fg_bad = 0;
      fg01   = 0;
      sig    = 0;
      for (int k = 0; k < n + 2; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            int ax;
            int ay;
            int rr;
            bit inb;
            ax  = x0 + (k - 2) % nx;
            ay  = y0 + (k - 2) / nx;
            inb = (ax >= X0) && (ax < X0 + 128) && (ay >= Y0) && (ay < Y0 + 32);
            rr  = (ay - Y0) / 2;
            if (vga.rgb === FG) begin
               fg_cnt++;
               sig = sig + ax * 1009 + ay * 7 + 1;
               if (!inb || rr < 2 || rr > 13) fg_bad++;
               if (inb && ax < X0 + 32) fg01++;
            end else if (vga.rgb !== BG) begin
               fg_bad++;
            end
         end
         if (k < n) drive(x0 + k % nx, y0 + k / nx, 1'b1);
      end
   endtask

   initial begin
      logic [2:0] c;
      int cnt, bad, c01, s1, s2, s3;

      vga.frame_start = 1'b0;
      drive(X0 + 6, Y0 + 8, 1'b1);

      // Reset held 3 clks with a visible in-box coordinate
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("reset_rgb", vga.rgb, OFF);
      end
      @(negedge clk);
      rst = 1'b0;

      pix(X0 + 38, Y0 + 8, 1'b1, c);
      chk("colon_after_reset", c, FG);
      sweep(X0, X0 + 15, Y0, Y0 + 31, cnt, bad, c01, s1);
      chk("reset_digit0_drawn", (cnt > 0), 1);
      chk("reset_digit0_padding", bad, 0);

      // Colon pixel after a shadow load
      hora = 8'h12; min = 8'h34; seg = 8'h56;
      pulse(1);
      pix(X0 + 38, Y0 + 8, 1'b1, c);  chk("colon_fg", c, FG);
      pix(X0 + 38, Y0 + 8, 1'b0, c);  chk("colon_video_off", c, OFF);
      pix(X0 + 38, Y0 + 10, 1'b1, c); chk("colon_row5", c, FG);
      pix(X0 + 38, Y0 + 12, 1'b1, c); chk("colon_row6", c, BG);
      pix(X0 + 36, Y0 + 8, 1'b1, c);  chk("colon_bit2", c, BG);
      pix(X0 + 41, Y0 + 8, 1'b1, c);  chk("colon_bit4", c, FG);
      pix(X0 + 86, Y0 + 8, 1'b1, c);  chk("colon2_fg", c, FG);

      // Bounds and padding rows
      pix(X0 - 1, Y0 + 8, 1'b1, c);   chk("left_of_box", c, BG);
      pix(X0 + 128, Y0 + 8, 1'b1, c); chk("right_of_box", c, BG);
      pix(X0 + 6, Y0 + 31, 1'b1, c);  chk("row15_cell0", c, BG);
      pix(X0 + 38, Y0 + 31, 1'b1, c); chk("row15_colon", c, BG);
      pix(X0 + 70, Y0 + 31, 1'b1, c); chk("row15_cell4", c, BG);

      // Latency: step from outside the box onto the colon
      @(negedge clk);
      drive(X0 - 1, Y0 + 8, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      drive(X0 + 38, Y0 + 8, 1'b1);
      @(posedge clk); #1; chk("latency_1clk", vga.rgb, BG);
      @(posedge clk); #1; chk("latency_2clk", vga.rgb, FG);
      @(posedge clk); #1; chk("latency_3clk", vga.rgb, FG);

      // Band around the box, full width, all 8s
      hora = 8'h88; min = 8'h59; seg = 8'h88;
      pulse(1);
      sweep(0, 639, Y0 - 2, Y0 + 33, cnt, bad, c01, s1);
      chk("sweep_fg_outside", bad, 0);
      chk("sweep_hora88_drawn", (c01 > 0), 1);

      // Invalid BCD hours
      hora = 8'hAF;
      pulse(1);
      sweep(X0, X0 + 31, Y0, Y0 + 31, cnt, bad, c01, s1);
      chk("hora_AF_blank", cnt, 0);

      // Shadowing of seconds
      seg = 8'h12;
      pulse(1);
      sweep(X0 + 96, X0 + 127, Y0, Y0 + 31, cnt, bad, c01, s1);
      chk("seg_drawn", (cnt > 0), 1);
      seg = 8'h47;
      sweep(X0 + 96, X0 + 127, Y0, Y0 + 31, cnt, bad, c01, s2);
      chk("seg_shadow_hold", s2, s1);
      pulse(1);
      sweep(X0 + 96, X0 + 127, Y0, Y0 + 31, cnt, bad, c01, s3);
      chk("seg_shadow_load", (s3 != s1), 1);

      // Mid-line reset with frame_start during reset
      pix(X0 + 38, Y0 + 8, 1'b1, c);
      chk("pre_reset_colon", c, FG);
      @(negedge clk);
      rst = 1'b1;
      vga.frame_start = 1'b1;
      @(posedge clk); #1; chk("rst_rise_rgb", vga.rgb, OFF);
      @(negedge clk);
      vga.frame_start = 1'b0;
      @(posedge clk); #1; chk("rst_hold_rgb", vga.rgb, OFF);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1; chk("refill_1clk", vga.rgb, OFF);
      @(posedge clk); #1; chk("refill_2clk", vga.rgb, FG);

      // Blink: counter restarts at 0 after reset
      pulse(29);
      pix(X0 + 38, Y0 + 8, 1'b1, c); chk("blink_29", c, FG);
      pulse(1);
      pix(X0 + 38, Y0 + 8, 1'b1, c); chk("blink_30", c, BG);
      pulse(29);
      pix(X0 + 38, Y0 + 8, 1'b1, c); chk("blink_59", c, BG);
      pulse(1);
      pix(X0 + 38, Y0 + 8, 1'b1, c); chk("blink_60", c, FG);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
